// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - EX-stage forwarding, load-use stall and multi-cycle multiplier hold control
// Optional feature macro: HAZARD_PERF_EN (adds saturating stall/multiplier perf counters)
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MULT_LAT   = 4
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W     = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_mult,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mult_busy,
  output logic                  mult_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_stall_cnt,
  output logic [PERF_W-1:0]     perf_mult_cnt
`endif
);

  localparam int CNT_W = $clog2(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LAT - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_raw;
  logic             done_raw;
  logic             lu;

  // Nearest producer wins: MEM result is younger than WB, so it takes priority; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic                  m_we,
                                         input logic [REG_ADDR_W-1:0] m_rd,
                                         input logic                  w_we,
                                         input logic [REG_ADDR_W-1:0] w_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd != '0) && (m_rd == rs))
      sel = 2'b01;
    else if (w_we && (w_rd != '0) && (w_rd == rs))
      sel = 2'b10;
    return sel;
  endfunction

  // Multiplier sequencer: counts down the remaining hold cycles once a MUL enters EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_is_mult) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
          else
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Busy starts the same cycle the MUL shows up in EX, so it must decode the live ex_is_mult.
  always_comb begin
    busy_raw = ((state == IDLE) && ex_is_mult) || ((state == BUSY) && (cnt != '0));
    done_raw = (state == BUSY) && (cnt == '0);
    lu       = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // Output decode; reset forces a free-running pipeline with no forwarding.
  always_comb begin
    fwd_a_sel    = 2'b00;
    fwd_b_sel    = 2'b00;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mult_busy    = 1'b0;
    mult_done    = 1'b0;
    if (!rst) begin
      fwd_a_sel = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      fwd_b_sel = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      mult_busy = busy_raw;
      mult_done = done_raw;
      if (busy_raw) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (lu) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters for load-use stall cycles and multiplier hold cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_mult_cnt  <= '0;
    end else begin
      if (lu && !busy_raw && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (busy_raw && (perf_mult_cnt != '1))
        perf_mult_cnt <= perf_mult_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - self-checking bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_mem_read, ex_is_mult, mem_reg_write, wb_reg_write;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_write, if_id_write, id_ex_write, id_ex_flush, ex_mem_flush, mult_busy, mult_done;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cnt, perf_mult_cnt;
`endif

  int checks = 0;
  int failures = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .MULT_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_is_mult(ex_is_mult),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mult_busy(mult_busy), .mult_done(mult_done)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_mult_cnt(perf_mult_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // {fa, fb, pc, ifid, idex, idf, exf, busy, done}
  function automatic logic [10:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic pc, input logic ifid, input logic idex,
                                     input logic idf, input logic exf, input logic busy,
                                     input logic done);
    return {fa, fb, pc, ifid, idex, idf, exf, busy, done};
  endfunction

  localparam logic [10:0] RUN   = 11'b00_00_111_00_00;
  localparam logic [10:0] HOLD  = 11'b00_00_000_01_10;
  localparam logic [10:0] STALL = 11'b00_00_001_10_00;
  localparam logic [10:0] DONE  = 11'b00_00_111_00_01;
  localparam logic [10:0] DONE_STALL = 11'b00_00_001_10_01;

  logic [10:0] exp_q[$];
  string       name_q[$];

  function automatic logic [10:0] actual();
    return {fwd_a_sel, fwd_b_sel, pc_write, if_id_write, id_ex_write,
            id_ex_flush, ex_mem_flush, mult_busy, mult_done};
  endfunction

  // Push expectation, let the cycle run, compare at the negative edge, advance past next posedge.
  task automatic step(input string name, input logic [10:0] e);
    logic [10:0] ev;
    string nm;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    ev = exp_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (actual() !== ev) begin
      failures++;
      $display("FAIL %s: got %b want %b", nm, actual(), ev);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_mem_read = 0; ex_is_mult = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_mem_read, mem_reg_write, wb_reg_write;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    //           name            idrs1 idrs2 exrs1 exrs2 exrd memrd wbrd  mread mwe  wwe
    vecs[0] = '{"mem_beats_wb",   0,    0,    5,    5,    0,   5,    5,   0,    1,   1,  mk(2'b01, 2'b01, 1,1,1,0,0,0,0)};
    vecs[1] = '{"x0_and_wb_b",    0,    0,    0,    7,    0,   0,    7,   0,    1,   1,  mk(2'b00, 2'b10, 1,1,1,0,0,0,0)};
    vecs[2] = '{"wb_only_a",      0,    0,    9,    4,    0,   0,    9,   0,    0,   1,  mk(2'b10, 2'b00, 1,1,1,0,0,0,0)};
    vecs[3] = '{"mem_no_write",   0,    0,    6,    0,    0,   6,    0,   0,    0,   0,  RUN};
    vecs[4] = '{"wb_x0",          0,    0,    0,    0,    0,   0,    0,   0,    0,   1,  RUN};
    vecs[5] = '{"lu_rs2",         0,    3,    0,    0,    3,   0,    0,   1,    0,   0,  STALL};
    vecs[6] = '{"lu_x0",          0,    0,    0,    0,    0,   0,    0,   1,    0,   0,  RUN};
    vecs[7] = '{"lu_rs1",         12,   1,    0,    0,    12,  0,    0,   1,    0,   0,  STALL};
    vecs[8] = '{"no_load",        12,   0,    0,    0,    12,  0,    0,   0,    0,   0,  RUN};
    vecs[9] = '{"split_ab",       0,    0,    3,    2,    0,   2,    3,   0,    1,   1,  mk(2'b10, 2'b01, 1,1,1,0,0,0,0)};

    clear_in();
    rst = 1;
    @(posedge clk);
    #1;
    // Reset gating: hazards and forwarding present on inputs must not show on outputs.
    mem_reg_write = 1; mem_rd = 5; ex_rs1 = 5; ex_is_mult = 1;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3;
    step("reset_gate", RUN);
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_stall_cnt !== 16'd0 || perf_mult_cnt !== 16'd0) begin
      failures++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_stall_cnt, perf_mult_cnt);
    end
`endif
    clear_in();
    rst = 0;
    step("idle_after_reset", RUN);

    foreach (vecs[i]) begin
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2;
      ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2; ex_rd = vecs[i].ex_rd;
      mem_rd = vecs[i].mem_rd; wb_rd = vecs[i].wb_rd;
      ex_mem_read = vecs[i].ex_mem_read; mem_reg_write = vecs[i].mem_reg_write;
      wb_reg_write = vecs[i].wb_reg_write;
      step(vecs[i].name, vecs[i].exp);
    end
    clear_in();

    // Two back-to-back MULs: 3 hold cycles then done, twice.
    ex_is_mult = 1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) step($sformatf("mul%0d_busy%0d", k, j), HOLD);
      step($sformatf("mul%0d_done", k), DONE);
    end
    ex_is_mult = 0;
    step("mul_drained", RUN);

    // MUL with load-use on ID: hold wins while busy, stall appears once the MUL completes.
    ex_is_mult = 1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3;
    for (int j = 0; j < 3; j++) step($sformatf("mul_lu_busy%0d", j), HOLD);
    step("mul_lu_done", DONE_STALL);
    ex_is_mult = 0;
    step("lu_after_mul", STALL);
    clear_in();
    step("lu_cleared", RUN);

    // Reset mid-MUL abandons the operation; a fresh MUL gets the full latency.
    ex_is_mult = 1;
    step("abort_busy0", HOLD);
    step("abort_busy1", HOLD);
    rst = 1;
    step("abort_in_reset", RUN);
    rst = 0;
    ex_is_mult = 0;
    step("abort_idle", RUN);
    ex_is_mult = 1;
    for (int j = 0; j < 3; j++) step($sformatf("restart_busy%0d", j), HOLD);
    step("restart_done", DONE);
    clear_in();
    step("final_idle", RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
